// File: rtl/cprv_if_stage_if.sv
// Fetch-stage bundle: instruction-memory request/response plus the ID-side valid/ready handshake.
// master = fetch stage, slave = memory/ID side (and the testbench).
interface cprv_if_stage_if #(
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH  = 64
);
    logic                   imem_req_o;
    logic [ADDR_WIDTH-1:0]  imem_addr_o;
    logic                   imem_rvalid_i;
    logic [INSTR_WIDTH-1:0] imem_rdata_i;
    logic                   redirect_i;
    logic [ADDR_WIDTH-1:0]  redirect_pc_i;
    logic                   valid_id_o;
    logic                   ready_id_i;
    logic [INSTR_WIDTH-1:0] instr_data_id_o;
    logic [ADDR_WIDTH-1:0]  pc_id_o;

    modport master (
        output imem_req_o, imem_addr_o, valid_id_o, instr_data_id_o, pc_id_o,
        input  imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, ready_id_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, valid_id_o, instr_data_id_o, pc_id_o,
        output imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, ready_id_i
    );
endinterface

// File: rtl/cprv_if_stage.sv
// cprv64g instruction-fetch stage: PC, 1-cycle-latency imem fetch, 2-entry output buffer, redirect.
// Optional CPRV_IF_MISALIGN_CHECK_EN: misaligned redirect target halts fetch and raises misalign_o.
module cprv_if_stage #(
    parameter int unsigned           INSTR_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH  = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic               clk,
    input  logic               rst,
    cprv_if_stage_if.master    bus
`ifdef CPRV_IF_MISALIGN_CHECK_EN
    ,
    output logic               misalign_o
`endif
);
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  req_pc_q, req_pc_d;
    logic                   outstanding_q, outstanding_d;
    logic                   flush_q, flush_d;
    logic [1:0]             count_q, count_d;
    logic                   head_q, head_d, tail_q, tail_d;
    logic [INSTR_WIDTH-1:0] instr_q [2];
    logic [ADDR_WIDTH-1:0]  epc_q [2];
    logic                   halt;
    logic                   valid, pop, issue, accept;
    logic [ADDR_WIDTH-1:0]  target;

`ifdef CPRV_IF_MISALIGN_CHECK_EN
    logic halt_q, halt_d;
    assign halt       = halt_q;
    assign misalign_o = halt_q;
    assign target     = bus.redirect_pc_i;

    always_comb begin
        halt_d = halt_q;
        if (bus.redirect_i) begin
            halt_d = |bus.redirect_pc_i[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end
`else
    assign halt   = 1'b0;
    assign target = bus.redirect_pc_i & ~{{(ADDR_WIDTH-2){1'b0}}, 2'b11};
`endif

    assign valid  = ~rst & (count_q != 2'd0);
    assign pop    = valid & bus.ready_id_i;
    // Occupancy includes the response landing this cycle, so the buffer can never overflow.
    assign issue  = ~rst & ~bus.redirect_i & ~halt &
                    (((count_q + {1'b0, outstanding_q}) < 2'd2) | pop);
    assign accept = bus.imem_rvalid_i & outstanding_q & ~flush_q;

    assign bus.imem_req_o      = issue;
    assign bus.imem_addr_o     = pc_q;
    assign bus.valid_id_o      = valid;
    assign bus.instr_data_id_o = instr_q[head_q];
    assign bus.pc_id_o         = epc_q[head_q];

    always_comb begin
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = issue;
        flush_d       = 1'b0;
        count_d       = count_q;
        head_d        = head_q;
        tail_d        = tail_q;
        if (bus.redirect_i) begin
            count_d = 2'd0;
            head_d  = 1'b0;
            tail_d  = 1'b0;
            pc_d    = target;
            flush_d = outstanding_q;
        end else begin
            if (issue) begin
                pc_d     = pc_q + ADDR_WIDTH'(4);
                req_pc_d = pc_q;
            end
            if (accept) begin
                tail_d = ~tail_q;
            end
            if (pop) begin
                head_d = ~head_q;
            end
            if (accept & ~pop) begin
                count_d = count_q + 2'd1;
            end else if (~accept & pop) begin
                count_d = count_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            req_pc_q      <= '0;
            outstanding_q <= 1'b0;
            flush_q       <= 1'b0;
            count_q       <= 2'd0;
            head_q        <= 1'b0;
            tail_q        <= 1'b0;
            instr_q[0]    <= '0;
            instr_q[1]    <= '0;
            epc_q[0]      <= '0;
            epc_q[1]      <= '0;
        end else begin
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            flush_q       <= flush_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            if (accept & ~bus.redirect_i) begin
                instr_q[tail_q] <= bus.imem_rdata_i;
                epc_q[tail_q]   <= req_pc_q;
            end
        end
    end
endmodule
